// File: rtl/memory_access_stage_if.sv
// Data-memory request/acknowledge port of the OTTER memory stage.
// The stage drives the request fields, the memory returns read data and ack.
interface memory_access_stage_if;
    logic        DMEM_REQ;
    logic        DMEM_WE;
    logic [31:0] DMEM_ADDR;
    logic [31:0] DMEM_WDATA;
    logic [3:0]  DMEM_BE;
    logic [31:0] DMEM_RDATA;
    logic        DMEM_ACK;

    modport master (
        output DMEM_REQ,
        output DMEM_WE,
        output DMEM_ADDR,
        output DMEM_WDATA,
        output DMEM_BE,
        input  DMEM_RDATA,
        input  DMEM_ACK
    );

    modport slave (
        input  DMEM_REQ,
        input  DMEM_WE,
        input  DMEM_ADDR,
        input  DMEM_WDATA,
        input  DMEM_BE,
        output DMEM_RDATA,
        output DMEM_ACK
    );
endinterface

// File: rtl/memory_access_stage.sv
// OTTER memory stage: req/ack data-memory access, load/store lane
// formatting, upstream stall and the MEM/WB pipeline register.
module memory_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        MEMORY_CLOCK,
    input  logic        MEMORY_RESET_N,
    input  logic [31:0] EXEC_PC_4,
    input  logic [31:0] EXEC_ALU_RESULT,
    input  logic [31:0] EXEC_RS2,
    input  logic [2:0]  EXEC_FUNCT3,
    input  logic [1:0]  EXEC_RF_WR_SEL,
    input  logic        EXEC_REGWRITE,
    input  logic        EXEC_MEMWRITE,
    input  logic        EXEC_MEMREAD2,
    input  logic [4:0]  EX_MS_RD,
    memory_access_stage_if.master dmem,
    output logic        MEM_STALL,
    output logic        MEM_ERR,
    output logic [31:0] FORWARD_MEM,
    output logic [31:0] MS_WB_PC_4,
    output logic [31:0] MS_WB_ALU_RESULT,
    output logic [31:0] MS_WB_LOAD_DATA,
    output logic [1:0]  MS_WB_RF_WR_SEL,
    output logic        MS_WB_REGWRITE,
    output logic [4:0]  MS_WB_RD
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ?
                        $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;

    logic        mem_op, is_wr, bad_f3, misal, illegal;
    logic [1:0]  ofs, size;
    logic        issue, done, abort, timeout;
    logic [3:0]  be_fmt;
    logic [31:0] wdata_fmt, lane, ld_fmt;

    assign FORWARD_MEM = EXEC_ALU_RESULT;
    assign mem_op  = EXEC_MEMREAD2 | EXEC_MEMWRITE;
    assign is_wr   = EXEC_MEMWRITE;
    assign ofs     = EXEC_ALU_RESULT[1:0];
    assign size    = EXEC_FUNCT3[1:0];
    assign bad_f3  = (EXEC_FUNCT3 == 3'b011) |
                     (EXEC_FUNCT3 == 3'b110) |
                     (EXEC_FUNCT3 == 3'b111);
    assign misal   = ((size == 2'b01) & ofs[0]) |
                     ((size == 2'b10) & (ofs != 2'b00));
    assign illegal = bad_f3 | misal;
    assign timeout = (cnt_q == CNT_LAST);

    always_comb begin
        be_fmt    = 4'b1111;
        wdata_fmt = EXEC_RS2;
        if (is_wr) begin
            unique case (1'b1)
                (size == 2'b00): begin
                    be_fmt    = 4'b0001 << ofs;
                    wdata_fmt = {4{EXEC_RS2[7:0]}};
                end
                (size == 2'b01): begin
                    be_fmt    = 4'b0011 << ofs;
                    wdata_fmt = {2{EXEC_RS2[15:0]}};
                end
                default: begin
                    be_fmt    = 4'b1111;
                    wdata_fmt = EXEC_RS2;
                end
            endcase
        end
    end

    // Shift the addressed byte/half down to lane 0 before extending.
    assign lane = dmem.DMEM_RDATA >> {ofs, 3'b000};

    always_comb begin
        ld_fmt = lane;
        unique case (1'b1)
            (EXEC_FUNCT3 == 3'b000):
                ld_fmt = {{24{lane[7]}}, lane[7:0]};
            (EXEC_FUNCT3 == 3'b001):
                ld_fmt = {{16{lane[15]}}, lane[15:0]};
            (EXEC_FUNCT3 == 3'b100):
                ld_fmt = {24'h0, lane[7:0]};
            (EXEC_FUNCT3 == 3'b101):
                ld_fmt = {16'h0, lane[15:0]};
            default:
                ld_fmt = lane;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        MEM_STALL = 1'b0;
        issue     = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_op && !illegal) begin
                    MEM_STALL = 1'b1;
                    issue     = 1'b1;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (dmem.DMEM_ACK) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (timeout) begin
                    // Aborted access leaves as a bubble this cycle.
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    MEM_STALL = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge MEMORY_CLOCK or negedge MEMORY_RESET_N) begin
        if (!MEMORY_RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ACCESS && !done && !abort)
                cnt_q <= cnt_q + 1'b1;
            else
                cnt_q <= '0;
        end
    end

    always_ff @(posedge MEMORY_CLOCK or negedge MEMORY_RESET_N) begin
        if (!MEMORY_RESET_N) begin
            dmem.DMEM_REQ    <= 1'b0;
            dmem.DMEM_WE     <= 1'b0;
            dmem.DMEM_ADDR   <= '0;
            dmem.DMEM_WDATA  <= '0;
            dmem.DMEM_BE     <= '0;
            MEM_ERR          <= 1'b0;
            MS_WB_PC_4       <= '0;
            MS_WB_ALU_RESULT <= '0;
            MS_WB_LOAD_DATA  <= '0;
            MS_WB_RF_WR_SEL  <= '0;
            MS_WB_REGWRITE   <= 1'b0;
            MS_WB_RD         <= '0;
        end else begin
            MEM_ERR <= 1'b0;
            if (issue) begin
                dmem.DMEM_REQ   <= 1'b1;
                dmem.DMEM_WE    <= is_wr;
                dmem.DMEM_ADDR  <= {EXEC_ALU_RESULT[31:2], 2'b00};
                dmem.DMEM_WDATA <= wdata_fmt;
                dmem.DMEM_BE    <= be_fmt;
                MS_WB_REGWRITE  <= 1'b0;
            end else if (done) begin
                dmem.DMEM_REQ    <= 1'b0;
                MS_WB_PC_4       <= EXEC_PC_4;
                MS_WB_ALU_RESULT <= EXEC_ALU_RESULT;
                MS_WB_LOAD_DATA  <= is_wr ? 32'h0 : ld_fmt;
                MS_WB_RF_WR_SEL  <= EXEC_RF_WR_SEL;
                MS_WB_REGWRITE   <= EXEC_REGWRITE;
                MS_WB_RD         <= EX_MS_RD;
            end else if (abort) begin
                dmem.DMEM_REQ  <= 1'b0;
                MEM_ERR        <= 1'b1;
                MS_WB_REGWRITE <= 1'b0;
            end else if (state_q == ACCESS) begin
                MS_WB_REGWRITE <= 1'b0;
            end else begin
                // Non-memory op, or an illegal access squashed to a bubble.
                MS_WB_PC_4       <= EXEC_PC_4;
                MS_WB_ALU_RESULT <= EXEC_ALU_RESULT;
                MS_WB_LOAD_DATA  <= '0;
                MS_WB_RF_WR_SEL  <= EXEC_RF_WR_SEL;
                MS_WB_REGWRITE   <= EXEC_REGWRITE & ~(mem_op & illegal);
                MS_WB_RD         <= EX_MS_RD;
                MEM_ERR          <= mem_op & illegal;
            end
        end
    end

endmodule
